// File: rtl/hamming_pkg.sv
// hamming_pkg: shared types and constants for the Hamming serial link
package hamming_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} pts_ctrl_state_t;
    localparam int PTS_WIDTH = 4;
endpackage

// File: rtl/pts_bit_timer.sv
// pts_bit_timer: splits clk into CLK_DIV-cycle bit times and ticks bit_end in the last cycle of each
module pts_bit_timer #(
    parameter int CLK_DIV = 1,
    parameter int CW      = 1
) (
    input  logic clk,
    input  logic pts_reset_n,
    input  logic clear,
    input  logic en,
    output logic bit_end
);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        bit_end = en && (cnt_q == LAST);
        cnt_d   = (clear || bit_end) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        cnt_q <= !pts_reset_n ? '0 : cnt_d;
    end
endmodule

// File: rtl/pts_tx_ctrl.sv
// pts_tx_ctrl: sequences load/shift/clear of the parallel-to-serial shifter, MSB first,
// and flags bit validity, frame start and completion to the downstream checker.
module pts_tx_ctrl #(
    parameter int WIDTH   = hamming_pkg::PTS_WIDTH,
    parameter int CLK_DIV = 1,
    parameter int GAP     = 1
) (
    input  logic                       clk,
    input  logic                       pts_reset_n,
    input  logic                       tx_valid,
    input  logic [WIDTH-1:0]           tx_data,
    output logic                       tx_ready,
    input  logic                       abort,
    output logic                       pts_write,
    output logic                       pts_shift,
    output logic [WIDTH-1:0]           pts_data,
    output logic                       pts_clear,
    output logic                       bit_valid,
    output logic [$clog2(WIDTH)-1:0]   bit_index,
    output logic                       frame_start,
    output logic                       done,
    output logic                       busy
);
    import hamming_pkg::*;
    localparam int IW = $clog2(WIDTH);
    localparam int MX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int CW = $clog2((MX > 2) ? MX : 2);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IW-1:0] TOP_IDX  = IW'(WIDTH - 1);

    pts_ctrl_state_t  state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    gap_q, gap_d;
    logic             clr_q, clr_d;
    logic             bit_end, last_bit, active;

    assign active   = state_q != IDLE;
    assign last_bit = idx_q == '0;

    pts_bit_timer #(.CLK_DIV(CLK_DIV), .CW(CW)) u_timer (
        .clk         (clk),
        .pts_reset_n (pts_reset_n),
        .clear       (state_q != SHIFT),
        .en          (state_q == SHIFT),
        .bit_end     (bit_end)
    );

    always_ff @(posedge clk) begin
        if (!pts_reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        clr_d   = 1'b0;
        if (abort && active) begin
            state_d = IDLE;
            gap_d   = '0;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = tx_valid ? LOAD : IDLE;
                    data_d  = tx_valid ? tx_data : data_q;
                end
                LOAD: begin
                    state_d = SHIFT;
                    idx_d   = TOP_IDX;
                end
                SHIFT: begin
                    idx_d   = (bit_end && !last_bit) ? idx_q - 1'b1 : idx_q;
                    state_d = !(bit_end && last_bit) ? SHIFT : (GAP > 0) ? hamming_pkg::GAP : IDLE;
                end
                default: begin
                    gap_d   = (gap_q == GAP_LAST) ? '0 : gap_q + 1'b1;
                    state_d = (gap_q == GAP_LAST) ? IDLE : state_q;
                end
            endcase
        end
    end

    // abort suppresses the bit-end strobes so the shifter is never advanced past a cancelled frame
    always_comb begin
        tx_ready    = pts_reset_n && state_q == IDLE;
        pts_write   = pts_reset_n && state_q == LOAD;
        frame_start = pts_write;
        bit_valid   = pts_reset_n && state_q == SHIFT;
        pts_shift   = bit_valid && bit_end && !last_bit && !abort;
        done        = bit_valid && bit_end && last_bit && !abort;
        busy        = pts_reset_n && active;
        bit_index   = bit_valid ? idx_q : '0;
        pts_data    = data_q;
        pts_clear   = !pts_reset_n || clr_q;
    end
endmodule

// File: tb/tb_pts_tx_ctrl.sv
// tb_pts_tx_ctrl: scoreboard bench driving three timing configurations of pts_tx_ctrl
// through a model of the downstream shifter.
module tb_pts_tx_ctrl;
    localparam int W  = 4;
    localparam int NI = 3;

    typedef struct {
        logic [W-1:0] w;
        int           t;
    } fr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [NI-1:0]        tx_valid, abort;
    logic [NI-1:0][W-1:0] tx_data;
    logic [NI-1:0]        tx_ready, pts_write, pts_shift, pts_clear, bit_valid, frame_start, done, busy, ser;
    logic [NI-1:0][W-1:0] pts_data;
    logic [NI-1:0][1:0]   bit_index;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int g, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h exp=%0h", tag, g, got, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int D = (g == 1) ? 3 : 1;
        logic [W-1:0] sh;
        fr_t q[$];
        fr_t cur;
        fr_t nf;
        int  k = 0;
        int  d = 0;
        bit  act = 0;

        pts_tx_ctrl #(.WIDTH(W), .CLK_DIV(D), .GAP((g == 2) ? 0 : 1)) dut (
            .clk         (clk),
            .pts_reset_n (rst_n),
            .tx_valid    (tx_valid[g]),
            .tx_data     (tx_data[g]),
            .tx_ready    (tx_ready[g]),
            .abort       (abort[g]),
            .pts_write   (pts_write[g]),
            .pts_shift   (pts_shift[g]),
            .pts_data    (pts_data[g]),
            .pts_clear   (pts_clear[g]),
            .bit_valid   (bit_valid[g]),
            .bit_index   (bit_index[g]),
            .frame_start (frame_start[g]),
            .done        (done[g]),
            .busy        (busy[g])
        );

        // downstream shifter: clear wins, then write, then shift left
        always @(posedge clk)
            sh <= pts_clear[g] ? '0 : pts_write[g] ? pts_data[g] : pts_shift[g] ? sh << 1 : sh;
        assign ser[g] = sh[W-1];

        always @(negedge clk) begin
            if (!rst_n) begin
                act = 0;
                q.delete();
            end else begin
                chk("wr_sh", g, {31'b0, pts_write[g] & pts_shift[g]}, 0);
                if (tx_valid[g] && tx_ready[g]) begin
                    nf.w = tx_data[g];
                    nf.t = cyc;
                    q.push_back(nf);
                end
                if (pts_write[g]) begin
                    chk("fs", g, frame_start[g], 1);
                    chk("q_sz", g, q.size(), 1);
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        chk("wr_t", g, cyc, cur.t + 1);
                    end
                    act = 1;
                    k = 0;
                    d = 0;
                end else if (act && abort[g]) begin
                    chk("ab_sup", g, {pts_shift[g], done[g]}, 0);
                    act = 0;
                end else if (act) begin
                    chk("bv", g, bit_valid[g], 1);
                    chk("ser", g, ser[g], cur.w[W-1-k]);
                    chk("idx", g, bit_index[g], W - 1 - k);
                    d++;
                    chk("sh", g, pts_shift[g], (d == D && k < W - 1));
                    chk("done", g, done[g], (d == D && k == W - 1));
                    if (d == D) begin
                        if (k == W - 1) begin
                            chk("done_t", g, cyc, cur.t + 1 + W * D);
                            act = 0;
                        end
                        d = 0;
                        k++;
                    end
                end else begin
                    chk("idle", g, {pts_shift[g], done[g], bit_valid[g]}, 0);
                end
            end
        end
    end

    task automatic send(input int g, input logic [W-1:0] w, output int t);
        bit hs = 0;
        @(posedge clk);
        #1;
        tx_valid[g] = 1'b1;
        tx_data[g]  = w;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk);
            if (tx_ready[g]) begin
                hs = 1;
                t  = cyc;
            end
        end
        chk("hs_to", g, {31'b0, hs}, 1);
        @(posedge clk);
        #1 tx_valid[g] = 1'b0;
    endtask

    task automatic wait_ready(input int g, output int t);
        bit ok = 0;
        t = -1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (tx_ready[g]) begin
                ok = 1;
                t  = cyc;
            end
        end
        chk("rdy_to", g, {31'b0, ok}, 1);
    endtask

    task automatic wait_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t, t2, t3;
        tx_valid = '0;
        tx_data  = '0;
        abort    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++)
            chk("rst_out", g, {tx_ready[g], pts_write[g], pts_shift[g], bit_valid[g],
                               frame_start[g], done[g], busy[g], pts_clear[g], bit_index[g], pts_data[g]},
                32'b00000001_00_0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++)
            chk("rel", g, {tx_ready[g], pts_clear[g], busy[g]}, 3'b100);

        // basic frame
        send(0, 4'b1011, t);
        wait_cyc(t + 6);
        chk("gap_rdy", 0, tx_ready[0], 0);
        chk("pdata", 0, pts_data[0], 4'b1011);
        @(negedge clk);
        chk("rdy_t7", 0, {tx_ready[0], busy[0]}, 2'b10);

        // divided bit rate
        send(1, 4'b0110, t);
        wait_ready(1, t2);
        chk("rdy_div", 1, t2, t + 2 + W * 3 + 1);

        // back-to-back with tx_valid held, no gap
        @(posedge clk);
        #1;
        tx_valid[2] = 1'b1;
        tx_data[2]  = 4'hA;
        wait_ready(2, t);
        @(posedge clk);
        #1 tx_data[2] = 4'h5;
        wait_ready(2, t2);
        chk("b2b", 2, t2 - t, 6);
        @(posedge clk);
        #1 tx_valid[2] = 1'b0;
        wait_ready(2, t3);
        chk("b2b_end", 2, t3 - t2, 6);

        // abort in the second bit time
        send(0, 4'hF, t);
        @(posedge clk);
        @(posedge clk);
        #1 abort[0] = 1'b1;
        @(posedge clk);
        #1 abort[0] = 1'b0;
        @(negedge clk);
        chk("ab_state", 0, {busy[0], pts_clear[0], tx_ready[0]}, 3'b011);
        @(negedge clk);
        chk("ab_clr", 0, {pts_clear[0], ser[0], tx_ready[0]}, 3'b001);
        repeat (4) @(negedge clk);

        // reset mid-SHIFT, then a fresh frame
        send(0, 4'b1100, t);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid", 0, {tx_ready[0], pts_write[0], pts_shift[0], bit_valid[0],
                           frame_start[0], done[0], busy[0], pts_clear[0], bit_index[0], pts_data[0]},
            32'b00000001_00_0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", 0, {tx_ready[0], pts_clear[0], ser[0]}, 3'b100);
        send(0, 4'b1001, t);
        wait_ready(0, t2);
        chk("rdy_after", 0, t2, t + 7);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pts_tx_ctrl.md
Name: pts_tx_ctrl

Overview:
Sequencer for the 4-bit parallel-to-serial shifter in the Hamming serial link. It accepts one word per valid/ready handshake and loads it into the shifter with write. It then pulses shift once per bit time, MSB first, and flags bit validity, frame start and completion to the downstream checker. It also owns the shifter's clear line, so aborts and resets leave the shifter at zero.

Parameters:
WIDTH, 4, word width; must match the shifter width; legal range is 2 or more.
CLK_DIV, 1, clk cycles per serial bit; legal range is 1 or more.
GAP, 1, idle cycles after the final bit before the next accept; legal range is 0 or more.

Ports:
clk  in  1  rising-edge clock
pts_reset_n  in  1  synchronous, active-low reset
tx_valid  in  1  word available on tx_data
tx_data  in  WIDTH  word to serialise; bit WIDTH-1 is sent first
tx_ready  out  1  controller can accept a word
abort  in  1  synchronous cancel of the current frame
pts_write  out  1  to shifter write
pts_shift  out  1  to shifter shift
pts_data  out  WIDTH  to shifter data_in; holds the captured word
pts_clear  out  1  to shifter pts_reset (active-high)
bit_valid  out  1  shifter serial_out carries a valid bit this cycle
bit_index  out  $clog2(WIDTH)  index of the bit on the line; counts WIDTH-1 down to 0
frame_start  out  1  one-cycle pulse in the load cycle
done  out  1  one-cycle pulse in the last cycle of the final bit
busy  out  1  state is not IDLE

Behaviour:
- States: IDLE, LOAD, SHIFT, GAP. Outputs are decoded from the registered state and counters.
- Reset is sampled at posedge while pts_reset_n=0:
  - state becomes IDLE and counters clear to 0.
  - pts_clear=1; every other output is 0, including tx_ready, which is gated by the reset input.
  - Reset mid-frame discards the frame with no done pulse.
- IDLE: tx_ready=1. If tx_valid=1 (T = handshake cycle), capture tx_data into pts_data and go to LOAD.
- LOAD (cycle T+1): pts_write=1 and frame_start=1. Go to SHIFT with bit_index=WIDTH-1 and the divider at 0.
- SHIFT: bit_valid=1.
  - Bit k occupies cycles T+2+k*CLK_DIV through T+1+(k+1)*CLK_DIV, for k=0..WIDTH-1.
  - pts_shift=1 in the last cycle of each bit time, except the final bit.
  - Non-final bit end: decrement bit_index and reset the divider.
  - Final bit end: done=1; go to GAP if GAP>0, else IDLE.
- GAP: counts GAP cycles, then goes to IDLE. tx_ready=0 throughout.
- Throughput: with tx_valid held high, the next handshake falls on cycle T+2+WIDTH*CLK_DIV+GAP.
- pts_write and pts_shift are never high in the same cycle. The shifter drives data_reg from two separate processes, so simultaneous assertion is illegal.
- abort:
  - In LOAD, SHIFT or GAP, abort=1 sends the state to IDLE at the next edge and pts_clear=1 for exactly that one following cycle.
  - No done pulse and no pts_shift is issued in the abort cycle.
  - abort in IDLE is ignored; a handshake in the same cycle proceeds normally.
- pts_data holds its value until the next handshake and resets to 0.
- The divider and GAP counters are sized $clog2(max(CLK_DIV,GAP,2)) bits and wrap only by explicit reset to 0.

Decomposition:
- Shared package hamming_pkg holds:
  - typedef enum logic [1:0] pts_ctrl_state_t {IDLE, LOAD, SHIFT, GAP}
  - localparam PTS_WIDTH=4
- One sub-module, pts_bit_timer, is natural. It is a CLK_DIV divider with a clear input and a bit_end tick output.
- The bit-index counter and FSM stay in pts_tx_ctrl.

Test Plan:
- Basic frame, WIDTH=4, CLK_DIV=1, GAP=1, tx_data=4'b1011 handshake at T:
  - pts_write and frame_start at T+1.
  - serial_out 1,0,1,1 at T+2..T+5, with bit_index 3,2,1,0.
  - pts_shift at T+2..T+4; done at T+5.
  - tx_ready again at T+7.
- Divided rate, CLK_DIV=3, tx_data=4'b0110:
  - each bit held 3 cycles, serial_out=0,1,1,0.
  - pts_shift at T+4, T+7, T+10; done at T+13.
- Back-to-back, tx_valid held with words 4'hA then 4'h5 and GAP=0:
  - second handshake at T+6.
  - serial stream 1,0,1,0,0,1,0,1 with no bubble beyond the load cycle.
- Abort asserted in the second bit time of 4'hF:
  - next cycle state IDLE, pts_clear=1 for one cycle.
  - serial_out=0 afterwards, no done, tx_ready=1.
- Reset with pts_reset_n=0 mid-SHIFT:
  - at the following edge all outputs are 0 except pts_clear=1.
  - after release, tx_ready=1 and a new 4'b1001 frame serialises correctly.
- Concurrent assertion over all runs: pts_write && pts_shift is never 1, and done is followed by no pts_shift within the same frame.
